// File: rtl/scr1_tapc_dmi_sync.sv
// scr1_tapc_dmi_sync: TCK -> clk bridge between the JTAG TAP controller and the DMI/DTM block.
// Optional 3-sample TCK majority filter: define SCR1_TAPC_SYNC_TCK_FILTER_EN.
module scr1_tapc_dmi_sync #(
    parameter int unsigned SYNC_STAGES              = 2,
    parameter int unsigned SCR1_DBG_DMI_CH_ID_WIDTH = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                tapc_trst_n,
    input  logic                                tapc_tck,
    input  logic                                tapc_ch_sel_i,
    input  logic [SCR1_DBG_DMI_CH_ID_WIDTH-1:0] tapc_ch_id_i,
    input  logic                                tapc_ch_capture_i,
    input  logic                                tapc_ch_shift_i,
    input  logic                                tapc_ch_update_i,
    input  logic                                tapc_ch_tdi_i,
    output logic                                tapc_ch_tdo_o,
    output logic                                tapcsync2dmi_ch_sel_o,
    output logic [SCR1_DBG_DMI_CH_ID_WIDTH-1:0] tapcsync2dmi_ch_id_o,
    output logic                                tapcsync2dmi_ch_capture_o,
    output logic                                tapcsync2dmi_ch_shift_o,
    output logic                                tapcsync2dmi_ch_update_o,
    output logic                                tapcsync2dmi_ch_tdi_o,
    input  logic                                dmi2tapcsync_ch_tdo_i
);

    localparam int unsigned ID_W    = SCR1_DBG_DMI_CH_ID_WIDTH;
    localparam int unsigned CTRL_W  = ID_W + 5;
    localparam int unsigned TDI_B   = 0;
    localparam int unsigned UPD_B   = 1;
    localparam int unsigned SHIFT_B = 2;
    localparam int unsigned CAP_B   = 3;
    localparam int unsigned SEL_B   = 4;
    localparam int unsigned ID_LSB  = 5;

    logic [CTRL_W-1:0]                   ctrl_in;
    logic [SYNC_STAGES-1:0]              tck_sync;
    logic [SYNC_STAGES-1:0]              trst_sync;
    logic [SYNC_STAGES-1:0][CTRL_W-1:0]  ctrl_sync;
    logic                                trst_rst_n;
    logic                                tck_s;
    logic                                tck_d;
    logic                                trst_s;
    logic [CTRL_W-1:0]                   ctrl_s;
    logic                                tck_rise;
    logic                                tck_fall;
    logic                                cap_c;
    logic                                shift_c;
    logic                                upd_c;

    assign ctrl_in = {tapc_ch_id_i, tapc_ch_sel_i, tapc_ch_capture_i,
                      tapc_ch_shift_i, tapc_ch_update_i, tapc_ch_tdi_i};

    // TCK and TAP control levels, sampled as plain data in the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_sync  <= '0;
            ctrl_sync <= '0;
        end else begin
            tck_sync  <= {tck_sync[SYNC_STAGES-2:0], tapc_tck};
            ctrl_sync <= {ctrl_sync[SYNC_STAGES-2:0], ctrl_in};
        end
    end

    // TAP reset: asserts immediately so in-flight pulses die, releases through the chain
    assign trst_rst_n = rst_n & tapc_trst_n;

    always_ff @(posedge clk or negedge trst_rst_n) begin
        if (!trst_rst_n) begin
            trst_sync <= '0;
        end else begin
            trst_sync <= {trst_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign trst_s = trst_sync[SYNC_STAGES-1];

`ifdef SCR1_TAPC_SYNC_TCK_FILTER_EN
    logic [1:0]        tck_hist;
    logic [CTRL_W-1:0] ctrl_dly;

    // Extra control stage keeps levels aligned with the one-clk-later filtered edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_hist <= '0;
            ctrl_dly <= '0;
        end else begin
            tck_hist <= {tck_hist[0], tck_sync[SYNC_STAGES-1]};
            ctrl_dly <= ctrl_sync[SYNC_STAGES-1];
        end
    end

    assign tck_s  = (tck_sync[SYNC_STAGES-1] & tck_hist[0])
                  | (tck_sync[SYNC_STAGES-1] & tck_hist[1])
                  | (tck_hist[0] & tck_hist[1]);
    assign ctrl_s = ctrl_dly;
`else
    assign tck_s  = tck_sync[SYNC_STAGES-1];
    assign ctrl_s = ctrl_sync[SYNC_STAGES-1];
`endif

    assign tck_rise = tck_s & ~tck_d;
    assign tck_fall = ~tck_s & tck_d;

    // One request per TCK rise; capture wins over shift, shift over update
    assign cap_c   = tck_rise & trst_s & ctrl_s[CAP_B];
    assign shift_c = tck_rise & trst_s & ctrl_s[SHIFT_B] & ~ctrl_s[CAP_B];
    assign upd_c   = tck_rise & trst_s & ctrl_s[UPD_B] & ~ctrl_s[SHIFT_B] & ~ctrl_s[CAP_B];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_d                     <= 1'b0;
            tapcsync2dmi_ch_capture_o <= 1'b0;
            tapcsync2dmi_ch_shift_o   <= 1'b0;
            tapcsync2dmi_ch_update_o  <= 1'b0;
            tapcsync2dmi_ch_sel_o     <= 1'b0;
            tapcsync2dmi_ch_id_o      <= '0;
            tapcsync2dmi_ch_tdi_o     <= 1'b0;
            tapc_ch_tdo_o             <= 1'b0;
        end else begin
            tck_d                     <= tck_s;
            tapcsync2dmi_ch_capture_o <= cap_c;
            tapcsync2dmi_ch_shift_o   <= shift_c;
            tapcsync2dmi_ch_update_o  <= upd_c;
            tapcsync2dmi_ch_sel_o     <= trst_s & ctrl_s[SEL_B];
            tapcsync2dmi_ch_id_o      <= trst_s ? ctrl_s[ID_LSB +: ID_W] : '0;
            if (tck_rise) begin
                tapcsync2dmi_ch_tdi_o <= ctrl_s[TDI_B];
            end
            // DMI TDO is settled well before the next TCK fall
            if (!trst_s) begin
                tapc_ch_tdo_o <= 1'b0;
            end else if (tck_fall) begin
                tapc_ch_tdo_o <= dmi2tapcsync_ch_tdo_i;
            end
        end
    end

endmodule

// File: tb/tb_scr1_tapc_dmi_sync.sv
// Directed bench for scr1_tapc_dmi_sync: reset, shift timing, DMI write, DTMCS read, TAP reset,
// priority, TCK filter (SCR1_TAPC_SYNC_TCK_FILTER_EN).
module tb_scr1_tapc_dmi_sync;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned ID_W        = 2;
`ifdef SCR1_TAPC_SYNC_TCK_FILTER_EN
    localparam int unsigned LAT = SYNC_STAGES + 2;
`else
    localparam int unsigned LAT = SYNC_STAGES + 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            trst_n;
    logic            tck;
    logic            sel;
    logic [ID_W-1:0] id;
    logic            cap;
    logic            sh;
    logic            upd;
    logic            tdi;
    logic            tdo_o;
    logic            sel_o;
    logic [ID_W-1:0] id_o;
    logic            cap_o;
    logic            sh_o;
    logic            upd_o;
    logic            tdi_o;
    logic            dmi_tdo;

    logic            model_en;
    logic            tdo_drv;
    logic [31:0]     dr;
    int              cap_tot = 0;
    int              sh_tot  = 0;
    int              upd_tot = 0;
    logic            upd_sel;
    logic [ID_W-1:0] upd_id;

    int checks   = 0;
    int failures = 0;

    scr1_tapc_dmi_sync #(
        .SYNC_STAGES              (SYNC_STAGES),
        .SCR1_DBG_DMI_CH_ID_WIDTH (ID_W)
    ) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .tapc_trst_n               (trst_n),
        .tapc_tck                  (tck),
        .tapc_ch_sel_i             (sel),
        .tapc_ch_id_i              (id),
        .tapc_ch_capture_i         (cap),
        .tapc_ch_shift_i           (sh),
        .tapc_ch_update_i          (upd),
        .tapc_ch_tdi_i             (tdi),
        .tapc_ch_tdo_o             (tdo_o),
        .tapcsync2dmi_ch_sel_o     (sel_o),
        .tapcsync2dmi_ch_id_o      (id_o),
        .tapcsync2dmi_ch_capture_o (cap_o),
        .tapcsync2dmi_ch_shift_o   (sh_o),
        .tapcsync2dmi_ch_update_o  (upd_o),
        .tapcsync2dmi_ch_tdi_o     (tdi_o),
        .dmi2tapcsync_ch_tdo_i     (dmi_tdo)
    );

    always #5 clk = ~clk;

    assign dmi_tdo = model_en ? dr[0] : tdo_drv;

    // Pulse monitor and a minimal DMI data register (DTMCS capture value 0x71)
    always @(posedge clk) begin
        if (cap_o) cap_tot++;
        if (sh_o)  sh_tot++;
        if (upd_o) begin
            upd_tot++;
            upd_sel = sel_o;
            upd_id  = id_o;
        end
        if (!model_en)  dr <= '0;
        else if (cap_o) dr <= 32'h0000_0071;
        else if (sh_o)  dr <= {tdi_o, dr[31:1]};
    end

    task automatic tck_cycle(input logic c, input logic s, input logic u, input logic d,
                             output logic t);
        tck = 1'b0; cap = c; sh = s; upd = u; tdi = d;
        repeat (5) @(negedge clk);
        t = tdo_o;
        repeat (3) @(negedge clk);
        tck = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        int s0;
        model_en = 1'b0;
        trst_n = 1'($urandom); tck = 1'($urandom); sel = 1'($urandom); id = ID_W'($urandom);
        cap = 1'($urandom); sh = 1'($urandom); upd = 1'($urandom); tdi = 1'($urandom);
        tdo_drv = 1'($urandom);
        repeat (3) @(negedge clk);
        checks += 8;
        if (tdo_o !== 1'b0) begin failures++; $display("FAIL reset_tdo: got %b want 0", tdo_o); end
        if (sel_o !== 1'b0) begin failures++; $display("FAIL reset_sel: got %b want 0", sel_o); end
        if (id_o !== '0)    begin failures++; $display("FAIL reset_id: got %0d want 0", id_o); end
        if (cap_o !== 1'b0) begin failures++; $display("FAIL reset_cap: got %b want 0", cap_o); end
        if (sh_o !== 1'b0)  begin failures++; $display("FAIL reset_shift: got %b want 0", sh_o); end
        if (upd_o !== 1'b0) begin failures++; $display("FAIL reset_upd: got %b want 0", upd_o); end
        if (tdi_o !== 1'b0) begin failures++; $display("FAIL reset_tdi: got %b want 0", tdi_o); end
        if (dmi_tdo === 1'bx) begin failures++; $display("FAIL reset_dmi_tdo: got x want 0/1"); end
        trst_n = 1'b1; tck = 1'b1; sel = 1'b1; id = ID_W'(2);
        cap = 1'b0; sh = 1'b1; upd = 1'b0; tdi = 1'b0; tdo_drv = 1'b0;
        repeat (2) @(negedge clk);
        s0 = sh_tot;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (sh_tot - s0 != 1) begin
            failures++; $display("FAIL reset_release_rise: got %0d pulses want 1", sh_tot - s0);
        end
    endtask

    task automatic test_shift();
        logic [3:0] tdi_pat = 4'b1101;
        logic [3:0] tdo_pat = 4'b0110;
        logic       exp_b;
        model_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tck = 1'b0; sh = 1'b1; cap = 1'b0; upd = 1'b0; tdi = tdi_pat[i];
            repeat (5) @(negedge clk);
            if (i > 0) begin
                checks++;
                if (tdo_o !== tdo_pat[i-1]) begin
                    failures++; $display("FAIL shift_tdo[%0d]: got %b want %b", i-1, tdo_o, tdo_pat[i-1]);
                end
            end
            repeat (3) @(negedge clk);
            tck = 1'b1;
            for (int k = 1; k <= int'(LAT) + 1; k++) begin
                @(negedge clk);
                exp_b = (k == int'(LAT));
                checks++;
                if (sh_o !== exp_b) begin
                    failures++; $display("FAIL shift_pulse[%0d] clk%0d: got %b want %b", i, k, sh_o, exp_b);
                end
            end
            checks++;
            if (tdi_o !== tdi_pat[i]) begin
                failures++; $display("FAIL shift_tdi[%0d]: got %b want %b", i, tdi_o, tdi_pat[i]);
            end
            tdo_drv = tdo_pat[i];
            repeat (8 - LAT - 1) @(negedge clk);
        end
        tck = 1'b0; sh = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (tdo_o !== tdo_pat[3]) begin
            failures++; $display("FAIL shift_tdo[3]: got %b want %b", tdo_o, tdo_pat[3]);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_dmi_write();
        int   c0, s0, u0;
        logic t;
        model_en = 1'b0; sel = 1'b1; id = ID_W'(2);
        c0 = cap_tot; s0 = sh_tot; u0 = upd_tot;
        tck_cycle(1'b1, 1'b0, 1'b0, 1'b0, t);
        for (int i = 0; i < 41; i++) tck_cycle(1'b0, 1'b1, 1'b0, 1'(i), t);
        tck_cycle(1'b0, 1'b0, 1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, 1'b0, 1'b0, t);
        checks += 3;
        if (cap_tot - c0 != 1)  begin failures++; $display("FAIL dmi_cap_cnt: got %0d want 1", cap_tot - c0); end
        if (sh_tot - s0 != 41)  begin failures++; $display("FAIL dmi_shift_cnt: got %0d want 41", sh_tot - s0); end
        if (upd_tot - u0 != 1)  begin failures++; $display("FAIL dmi_upd_cnt: got %0d want 1", upd_tot - u0); end
        checks += 2;
        if (upd_sel !== 1'b1)   begin failures++; $display("FAIL dmi_upd_sel: got %b want 1", upd_sel); end
        if (upd_id !== ID_W'(2)) begin failures++; $display("FAIL dmi_upd_id: got %0d want 2", upd_id); end
    endtask

    task automatic test_dtmcs_read();
        logic [31:0] rd;
        logic        t;
        sel = 1'b1; id = ID_W'(1); model_en = 1'b1;
        tck_cycle(1'b1, 1'b0, 1'b0, 1'b0, t);
        for (int i = 0; i < 32; i++) begin
            tck_cycle(1'b0, 1'b1, 1'b0, 1'b0, t);
            rd[i] = t;
        end
        tck_cycle(1'b0, 1'b0, 1'b0, 1'b0, t);
        checks++;
        if (rd !== 32'h0000_0071) begin
            failures++; $display("FAIL dtmcs_stream: got %08h want 00000071", rd);
        end
    endtask

    task automatic test_tdo_load();
        logic t;
        model_en = 1'b0; tdo_drv = 1'b1;
        tck_cycle(1'b0, 1'b0, 1'b0, 1'b0, t);
        checks++;
        if (t !== 1'b1) begin failures++; $display("FAIL tdo_load: got %b want 1", t); end
    endtask

    task automatic test_trst();
        int u0;
        tck = 1'b0; sel = 1'b1; id = ID_W'(2); cap = 1'b0; sh = 1'b0; upd = 1'b1;
        repeat (8) @(negedge clk);
        u0 = upd_tot;
        tck = 1'b1;
        @(negedge clk);
        trst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (tdo_o !== 1'b0) begin failures++; $display("FAIL trst_tdo: got %b want 0", tdo_o); end
        repeat (SYNC_STAGES) @(negedge clk);
        checks += 2;
        if (sel_o !== 1'b0) begin failures++; $display("FAIL trst_sel: got %b want 0", sel_o); end
        if (id_o !== '0)    begin failures++; $display("FAIL trst_id: got %0d want 0", id_o); end
        repeat (6) @(negedge clk);
        checks++;
        if (upd_tot != u0) begin failures++; $display("FAIL trst_upd_drop: got %0d pulses want 0", upd_tot - u0); end
        trst_n = 1'b1; tck = 1'b0; upd = 1'b0;
        repeat (8) @(negedge clk);
        checks += 2;
        if (sel_o !== 1'b1)     begin failures++; $display("FAIL trst_release_sel: got %b want 1", sel_o); end
        if (id_o !== ID_W'(2))  begin failures++; $display("FAIL trst_release_id: got %0d want 2", id_o); end
    endtask

    task automatic test_priority();
        int   c0, s0, u0;
        logic t;
        c0 = cap_tot; s0 = sh_tot; u0 = upd_tot;
        tck_cycle(1'b1, 1'b1, 1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b1, 1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, 1'b0, 1'b0, t);
        checks += 3;
        if (cap_tot - c0 != 1) begin failures++; $display("FAIL prio_cap: got %0d want 1", cap_tot - c0); end
        if (sh_tot - s0 != 1)  begin failures++; $display("FAIL prio_shift: got %0d want 1", sh_tot - s0); end
        if (upd_tot - u0 != 0) begin failures++; $display("FAIL prio_upd: got %0d want 0", upd_tot - u0); end
    endtask

    task automatic test_filter();
        logic exp_b;
        tck = 1'b0; cap = 1'b0; sh = 1'b0; upd = 1'b1; sel = 1'b1; id = ID_W'(2);
        repeat (8) @(negedge clk);
`ifdef SCR1_TAPC_SYNC_TCK_FILTER_EN
        begin
            int u0;
            u0 = upd_tot;
            tck = 1'b1;
            @(negedge clk);
            tck = 1'b0;
            repeat (8) @(negedge clk);
            checks++;
            if (upd_tot != u0) begin failures++; $display("FAIL filter_glitch: got %0d pulses want 0", upd_tot - u0); end
        end
`endif
        tck = 1'b1;
        for (int k = 1; k <= int'(LAT) + 1; k++) begin
            @(negedge clk);
            exp_b = (k == int'(LAT));
            checks++;
            if (upd_o !== exp_b) begin
                failures++; $display("FAIL edge_latency clk%0d: got %b want %b", k, upd_o, exp_b);
            end
        end
        repeat (4) @(negedge clk);
        tck = 1'b0; upd = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_shift();
        test_dmi_write();
        test_dtmcs_read();
        test_tdo_load();
        test_trst();
        test_priority();
        test_filter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
